// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: pattern modes and
// default visible-area dimensions.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_VBAND = 2'd0,
        MODE_HBAND = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } vga_mode_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/vga_band_counter.sv
// Band counter: a sub-band position that wraps at BAND and a band index that
// wraps at NB, avoiding any divide of the raw pixel/line coordinate.
module vga_band_counter #(
    parameter int BAND = 50,
    parameter int NB   = 12,
    parameter int IW   = 4,
    parameter int SW   = (BAND > 1) ? $clog2(BAND) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [IW-1:0] load_idx,
    output logic [IW-1:0] idx
);

    logic [SW-1:0] sub_r;
    logic [IW-1:0] idx_r;

    assign idx = idx_r;

    // Load has priority over step so a line/frame start always resynchronises.
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_r <= '0;
            idx_r <= '0;
        end else if (load) begin
            sub_r <= '0;
            idx_r <= load_idx;
        end else if (step) begin
            if (sub_r == SW'(BAND - 1)) begin
                sub_r <= '0;
                idx_r <= (idx_r == IW'(NB - 1)) ? '0 : idx_r + IW'(1);
            end else begin
                sub_r <= sub_r + SW'(1);
                idx_r <= idx_r;
            end
        end else begin
            sub_r <= sub_r;
            idx_r <= idx_r;
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage VGA test-pattern generator (bands, checkerboard, solid).
// Define VGA_PATTERN_SCROLL_EN to rotate the vertical bands by one per frame.
module vga_pattern_gen #(
    parameter int CW       = 2,
    parameter int BAND     = 50,
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE_DEF,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [10:0]   hcount,
    input  logic [9:0]    vcount,
    input  logic [1:0]    mode_in,
    input  logic          mode_we,
    output logic [CW-1:0] r,
    output logic [CW-1:0] g,
    output logic [CW-1:0] b,
    output logic          active_out,
    output logic          frame_start
);

    import vga_pkg::*;

    localparam int NB = 3 * (1 << CW);
    localparam int IW = CW + 2;

    logic            line_start_s;
    logic            frame_start_s;
    logic [IW-1:0]   v_start_s;
    logic [IW-1:0]   h_idx_s;
    logic [IW-1:0]   v_idx_s;
    logic [3*CW-1:0] rgb_s;

    vga_mode_e       mode_pend_r;
    vga_mode_e       mode_act_r;
    logic            vis_r;
    logic            fs1_r;

    // Index k selects channel k/2^CW at level k mod 2^CW; packed as {r,g,b}.
    function automatic logic [3*CW-1:0] band_colour(input logic [IW-1:0] k);
        logic [CW-1:0]   lvl;
        logic [1:0]      chan;
        logic [3*CW-1:0] c;
        lvl  = k[CW-1:0];
        chan = k[IW-1:CW];
        case (chan)
            2'd0:    c = {lvl, {(2*CW){1'b0}}};
            2'd1:    c = {{CW{1'b0}}, lvl, {CW{1'b0}}};
            2'd2:    c = {{(2*CW){1'b0}}, lvl};
            default: c = '0;
        endcase
        return c;
    endfunction

    assign line_start_s  = (hcount == 11'd0);
    assign frame_start_s = (hcount == 11'd0) && (vcount == 10'd0);

`ifdef VGA_PATTERN_SCROLL_EN
    logic [IW-1:0] scroll_idx_r;

    assign v_start_s = scroll_idx_r;

    // Advance the vertical start band once per frame, after it has been loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_idx_r <= '0;
        end else if (frame_start_s) begin
            scroll_idx_r <= (scroll_idx_r == IW'(NB - 1)) ? '0 : scroll_idx_r + IW'(1);
        end else begin
            scroll_idx_r <= scroll_idx_r;
        end
    end
`else
    assign v_start_s = '0;
`endif

    // Stage 1 band indices: the counter registers track the pixel presented this cycle.
    vga_band_counter #(.BAND(BAND), .NB(NB), .IW(IW)) u_h_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (line_start_s),
        .step     (1'b1),
        .load_idx ({IW{1'b0}}),
        .idx      (h_idx_s)
    );

    vga_band_counter #(.BAND(BAND), .NB(NB), .IW(IW)) u_v_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (frame_start_s),
        .step     (line_start_s),
        .load_idx (v_start_s),
        .idx      (v_idx_s)
    );

    // Pending mode captures every write; the active mode switches only at frame start,
    // taking a coincident write directly so it applies to that same frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_pend_r <= MODE_VBAND;
            mode_act_r  <= MODE_VBAND;
        end else begin
            if (mode_we) begin
                mode_pend_r <= vga_mode_e'(mode_in);
            end else begin
                mode_pend_r <= mode_pend_r;
            end
            if (frame_start_s) begin
                mode_act_r <= mode_we ? vga_mode_e'(mode_in) : mode_pend_r;
            end else begin
                mode_act_r <= mode_act_r;
            end
        end
    end

    // Stage 1 visibility and frame-start flags, aligned with the band indices.
    always_ff @(posedge clk) begin
        if (rst) begin
            vis_r <= 1'b0;
            fs1_r <= 1'b0;
        end else begin
            vis_r <= (hcount < 11'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
            fs1_r <= frame_start_s;
        end
    end

    // Pattern selection from the stage-1 indices; blanked pixels are black.
    always_comb begin
        rgb_s = '0;
        if (vis_r) begin
            case (mode_act_r)
                MODE_VBAND: rgb_s = band_colour(v_idx_s);
                MODE_HBAND: rgb_s = band_colour(h_idx_s);
                MODE_CHECK: rgb_s = (h_idx_s[0] ^ v_idx_s[0]) ? {(3*CW){1'b1}} : '0;
                MODE_SOLID: rgb_s = {(3*CW){1'b1}};
                default:    rgb_s = '0;
            endcase
        end else begin
            rgb_s = '0;
        end
    end

    // Stage 2 output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            active_out  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            r           <= rgb_s[3*CW-1:2*CW];
            g           <= rgb_s[2*CW-1:CW];
            b           <= rgb_s[CW-1:0];
            active_out  <= vis_r;
            frame_start <= fs1_r;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: a vector table probed through short-line
// rasters, plus hand sequences for mode writes, mid-frame reset and scrolling.
module tb_vga_pattern_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [1:0]  mode_in;
    logic        mode_we;
    logic [1:0]  r, g, b;
    logic        active_out;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] mode;
        int         h;
        int         v;
        logic [1:0] er;
        logic [1:0] eg;
        logic [1:0] eb;
        logic       eact;
    } vec_t;

    vec_t vecs[17];

    vga_pattern_gen dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .mode_in     (mode_in),
        .mode_we     (mode_we),
        .r           (r),
        .g           (g),
        .b           (b),
        .active_out  (active_out),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic px(input int x, input int y, input logic we, input logic [1:0] m);
        hcount  = 11'(x);
        vcount  = 10'(y);
        mode_we = we;
        mode_in = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        mode_we = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Runs one frame of 4-pixel lines from (0,0) up to line v, which extends to h+1;
    // on return the outputs belong to pixel (h,v).
    task automatic probe(input logic [1:0] m, input logic we_start, input int h, input int v);
        for (int y = 0; y <= v; y++) begin
            int len;
            len = (y == v) ? h + 2 : 4;
            for (int x = 0; x < len; x++) begin
                px(x, y, we_start && (x == 0) && (y == 0), m);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'd0,  10,  60, 2'd1, 2'd0, 2'd0, 1'b1};
        vecs[1]  = '{2'd0,  10, 260, 2'd0, 2'd1, 2'd0, 1'b1};
        vecs[2]  = '{2'd0,  10, 460, 2'd0, 2'd0, 2'd1, 1'b1};
        vecs[3]  = '{2'd0,  10,  10, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[4]  = '{2'd0,  10, 150, 2'd3, 2'd0, 2'd0, 1'b1};
        vecs[5]  = '{2'd1,  60,   0, 2'd1, 2'd0, 2'd0, 1'b1};
        vecs[6]  = '{2'd1, 310,   0, 2'd0, 2'd2, 2'd0, 1'b1};
        vecs[7]  = '{2'd1, 599,   2, 2'd0, 2'd0, 2'd3, 1'b1};
        vecs[8]  = '{2'd1, 630,   2, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[9]  = '{2'd1,  49,   1, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[10] = '{2'd1,  50,   1, 2'd1, 2'd0, 2'd0, 1'b1};
        vecs[11] = '{2'd2,  60,  10, 2'd3, 2'd3, 2'd3, 1'b1};
        vecs[12] = '{2'd2,  60,  60, 2'd0, 2'd0, 2'd0, 1'b1};
        vecs[13] = '{2'd3,   5,   3, 2'd3, 2'd3, 2'd3, 1'b1};
        vecs[14] = '{2'd3, 700,   5, 2'd0, 2'd0, 2'd0, 1'b0};
        vecs[15] = '{2'd3, 639, 479, 2'd3, 2'd3, 2'd3, 1'b1};
        vecs[16] = '{2'd3,   0, 480, 2'd0, 2'd0, 2'd0, 1'b0};

        hcount  = 11'd5;
        vcount  = 10'd5;
        mode_in = 2'd0;
        mode_we = 1'b0;

        // Reset state
        do_reset();
        chk("reset_r", 32'(r), 32'd0);
        chk("reset_g", 32'(g), 32'd0);
        chk("reset_b", 32'(b), 32'd0);
        chk("reset_active", 32'(active_out), 32'd0);
        chk("reset_fs", 32'(frame_start), 32'd0);

        // Vector table, each in a fresh frame with the mode written at frame start
        for (int i = 0; i < 17; i++) begin
            do_reset();
            probe(vecs[i].mode, 1'b1, vecs[i].h, vecs[i].v);
            chk($sformatf("vec%0d_r", i), 32'(r), 32'(vecs[i].er));
            chk($sformatf("vec%0d_g", i), 32'(g), 32'(vecs[i].eg));
            chk($sformatf("vec%0d_b", i), 32'(b), 32'(vecs[i].eb));
            chk($sformatf("vec%0d_act", i), 32'(active_out), 32'(vecs[i].eact));
            chk($sformatf("vec%0d_fs", i), 32'(frame_start), 32'd0);
        end

        // Mid-frame back-to-back mode writes take effect only at the next frame start
        do_reset();
        for (int y = 0; y < 150; y++) begin
            for (int x = 0; x < 4; x++) begin
                px(x, y, (y == 100) && (x == 1 || x == 2), (x == 1) ? 2'd1 : 2'd3);
            end
        end
        for (int x = 0; x <= 11; x++) px(x, 150, 1'b0, 2'd0);
        chk("midwr_old_r", 32'(r), 32'd3);
        chk("midwr_old_g", 32'(g), 32'd0);
        chk("midwr_old_fs", 32'(frame_start), 32'd0);
        px(0, 0, 1'b0, 2'd0);
        px(1, 0, 1'b0, 2'd0);
        chk("midwr_new_r", 32'(r), 32'd3);
        chk("midwr_new_g", 32'(g), 32'd3);
        chk("midwr_new_b", 32'(b), 32'd3);
        chk("midwr_fs_pulse", 32'(frame_start), 32'd1);
        px(2, 0, 1'b0, 2'd0);
        chk("midwr_fs_once", 32'(frame_start), 32'd0);

        // Reset mid-frame at line 200 with a competing mode write
        do_reset();
        for (int y = 0; y < 200; y++) begin
            for (int x = 0; x < 4; x++) px(x, y, (x == 0) && (y == 0), 2'd3);
        end
        for (int x = 0; x < 6; x++) px(x, 200, 1'b0, 2'd3);
        chk("rstmid_pre_r", 32'(r), 32'd3);
        rst = 1'b1;
        px(6, 200, 1'b1, 2'd2);
        rst = 1'b0;
        chk("rstmid_r", 32'(r), 32'd0);
        chk("rstmid_g", 32'(g), 32'd0);
        chk("rstmid_b", 32'(b), 32'd0);
        chk("rstmid_act", 32'(active_out), 32'd0);
        for (int x = 7; x < 13; x++) px(x, 200, 1'b0, 2'd0);
        for (int x = 0; x <= 61; x++) px(x, 201, 1'b0, 2'd0);
        chk("rstmid_line_r", 32'(r), 32'd0);
        chk("rstmid_line_g", 32'(g), 32'd0);
        chk("rstmid_line_act", 32'(active_out), 32'd1);
        probe(2'd0, 1'b0, 10, 60);
        chk("rstmid_nextfr_r", 32'(r), 32'd1);
        chk("rstmid_nextfr_g", 32'(g), 32'd0);

`ifdef VGA_PATTERN_SCROLL_EN
        // Vertical bands rotate by one per frame and wrap after NB frames
        do_reset();
        for (int f = 1; f <= 13; f++) begin
            probe(2'd0, 1'b0, 1, 0);
            if (f == 2) begin
                chk("scroll_f2_r", 32'(r), 32'd1);
                chk("scroll_f2_g", 32'(g), 32'd0);
            end else if (f == 13) begin
                chk("scroll_f13_r", 32'(r), 32'd0);
                chk("scroll_f13_act", 32'(active_out), 32'd1);
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 Parameter CW, default 2: colour bits per channel.
REQ-002 Parameter BAND, default 50: band size in pixels (horizontal) and lines (vertical).
REQ-003 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 hcount  in  11  current pixel column; SHALL increment by 1 per clk, returning to 0 at line start.
REQ-008 vcount  in  10  current line; changes only when hcount==0.
REQ-009 mode_in  in  2  requested pattern mode.
REQ-010 mode_we  in  1  one-cycle write strobe for mode_in.
REQ-011 r, g, b  out  CW each  registered colour outputs.
REQ-012 active_out  out  1  high when the output pixel is visible.
REQ-013 frame_start  out  1  one-cycle pulse aligned with output pixel (0,0).

Function
REQ-014 Total latency SHALL be 2 cycles: stage 1 registers band indices and visibility; stage 2 registers colours, active_out and frame_start.
REQ-015 The horizontal counter SHALL load h_sub=0, h_idx=0 when hcount==0; otherwise h_sub increments, and at h_sub==BAND-1 it wraps to 0 and h_idx increments. No divider is used.
REQ-016 The vertical counter SHALL advance the same way, stepping once per line on hcount==0 and loading its start value when hcount==0 and vcount==0.
REQ-017 Band indices SHALL wrap modulo NB = 3*2^CW.
REQ-018 Colour map for index k: channel = k / 2^CW (0=r, 1=g, 2=b), level = k mod 2^CW; the other two channels are 0.
REQ-019 Mode 0 (VBAND): colour map applied to v_idx.
REQ-020 Mode 1 (HBAND): colour map applied to h_idx.
REQ-021 Mode 2 (CHECK): if h_idx[0] XOR v_idx[0] is 1, all channels are at maximum; otherwise all are 0.
REQ-022 Mode 3 (SOLID): all channels at maximum (2^CW-1).
REQ-023 When hcount>=H_ACTIVE or vcount>=V_ACTIVE, r, g and b SHALL be 0 and active_out SHALL be 0.
REQ-024 mode_we SHALL latch mode_in into mode_pend; the active mode SHALL update only at frame start (hcount==0 and vcount==0).
REQ-025 If mode_we coincides with frame start, mode_in SHALL take effect immediately for that frame (write-through).
REQ-026 Back-to-back mode_we: the last write before frame start wins.

Reset
REQ-027 rst SHALL clear r, g, b, active_out, frame_start, the pipeline, all counters, mode_pend, the active mode (0) and scroll_idx (0).
REQ-028 Reset mid-frame: after release, counters SHALL resynchronise at the next hcount==0; until then they count from 0.
REQ-029 rst SHALL take priority over mode_we.

Configuration
REQ-030 With VGA_PATTERN_SCROLL_EN defined, scroll_idx SHALL increment modulo NB at each frame start, after being loaded as the v_idx start value; modes 0 and 2 then rotate by one band per frame.
REQ-031 Without VGA_PATTERN_SCROLL_EN, scroll_idx SHALL be absent and v_idx SHALL start at 0.

Structure
REQ-032 Shared package vga_pkg SHALL hold the mode constants MODE_VBAND=0, MODE_HBAND=1, MODE_CHECK=2, MODE_SOLID=3 and the default H_ACTIVE/V_ACTIVE.
REQ-033 Sub-module vga_band_counter (sub/idx counter with load value, parametrised BAND and NB) SHALL be instantiated twice, once for h and once for v.

Verification (CW=2, BAND=50, scroll off unless stated)
REQ-034 Mode 0: v=60, h=10 -> 2 cycles later r=1, g=0, b=0; v=260 -> g=1, others 0; v=460 -> b=1, others 0.
REQ-035 Blanking: h=700, any v -> r=g=b=0, active_out=0; h=639, v=479 -> active_out=1.
REQ-036 Mode write mid-frame: mode_we with mode_in=3 at v=100 -> no output change until frame start; then r=g=b=3 and frame_start pulses once.
REQ-037 Mode 2: h=60, v=10 -> r=g=b=3; h=60, v=60 -> r=g=b=0.
REQ-038 VGA_PATTERN_SCROLL_EN: second frame after reset, v=0, mode 0 -> r=1; thirteenth frame -> r=0 (wrap at NB=12).
REQ-039 rst asserted at v=200 -> next cycle r=g=b=0 and mode=0; output is correct from the next line start.
